rr_ring_arbiter: RTL

- Round-robin arbiter that shares one resource among N requesters.
- Priority pointer is a one-hot rotating token, i.e. a ring counter, which advances past each serviced requester.
- Sits between N requester blocks and one shared datapath; grant is registered and held until the owner releases.
- Optional hold timeout keeps one requester from owning the resource indefinitely.

---
 rtl/rr_ring_arbiter_pkg.sv | 23 ++
 rtl/ring_token_reg.sv | 32 +++
 rtl/rr_ring_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the rr_ring_arbiter slice.
// Optional hold timeout is compiled in with RR_ARB_TIMEOUT_EN.
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Index of the set bit of a one-hot vector (up to 16 requesters).
    function automatic int oh2idx(input logic [15:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_token_reg.sv
// One-hot priority ring counter. Resets to bit0; on adv it loads the
// position just past the serviced owner (rotate left by one, with wrap).
module ring_token_reg
    import rr_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    input  logic [N-1:0] owner_oh,
    output logic [N-1:0] token
);

    logic [N-1:0] token_d;
    logic [N-1:0] token_q;

    // Next token: hold, or step past the releasing owner.
    always_comb begin
        token_d = token_q;
        if (adv) token_d = {owner_oh[N-2:0], owner_oh[N-1]};
    end

    // Token register, async reset to bit0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) token_q <= N'(1);
        else        token_q <= token_d;
    end

    assign token = token_q;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token.
// Grant is registered and held until the owner releases (done or req drop).
// Define RR_ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic [N-1:0]   token
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic           timeout
`endif
);

    if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
        $error("rr_ring_arbiter: N must be 2..16 and MAX_HOLD 1..255");
    end

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [N-1:0]   token_q;
    logic           adv;

    logic [15:0]    tok16;
    logic [N-1:0]   req_rot;
    int             tidx, pick, win;
    logic           own_done, own_drop, rel;

    ring_token_reg #(.N(N)) u_token (
        .clk      (clk),
        .rst_n    (reset),
        .adv      (adv),
        .owner_oh (grant_q),
        .token    (token_q)
    );

    // Winner: rotate req so the token bit is at 0, take lowest set bit,
    // rotate the index back.
    always_comb begin
        tok16          = '0;
        tok16[N-1:0]   = token_q;
        tidx           = oh2idx(tok16);
        for (int k = 0; k < N; k++) begin
            req_rot[k] = req[IDW'((tidx + k) % N)];
        end
        pick = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) pick = k;
        end
        win = (tidx + pick) % N;
    end

    // Only the current owner's done/req bits can end a grant.
    assign own_done = |(done & grant_q);
    assign own_drop = ~|(req & grant_q);

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
    logic       forced;

    assign forced = (hold_cnt_q == HOLD_LAST);
    assign rel    = own_done | own_drop | forced;

    // Hold counter and timeout pulse; a coincident normal release wins.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            hold_cnt_d = '0;
        end else if (rel) begin
            hold_cnt_d = '0;
            timeout_d  = forced & ~own_done & ~own_drop;
        end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign rel = own_done | own_drop;
`endif

    // FSM next state: grant the winner from IDLE, drop to IDLE on release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    grant_d = N'(1) << win;
                    gid_d   = IDW'(win);
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    gid_d   = '0;
                    adv     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and grant registers, async reset drops any grant at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign busy     = (state_q == ST_GRANT);
    assign token    = token_q;

endmodule
